// File: rtl/hbridge_pkg.sv
// Shared types and constants for the H-bridge dead-time driver: states,
// request encodings, fault-cause bit positions and the state-to-gate decode.
package hbridge_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_POS,
    ST_NEG,
    ST_DEAD,
    ST_FAULT
  } state_e;

  localparam logic [1:0] CMD_OFF = 2'b00;
  localparam logic [1:0] CMD_POS = 2'b10;
  localparam logic [1:0] CMD_NEG = 2'b01;
  localparam logic [1:0] CMD_ILL = 2'b11;

  localparam int CAUSE_ILL = 0;
  localparam int CAUSE_EXT = 1;

  typedef struct packed {
    logic a_hi;
    logic a_lo;
    logic b_hi;
    logic b_lo;
  } gates_t;

  // Only POS and NEG conduct; every other state holds the bridge fully off.
  function automatic gates_t gate_decode(input state_e s);
    gates_t g;
    g = '0;
    case (s)
      ST_POS: begin
        g.a_hi = 1'b1;
        g.b_lo = 1'b1;
      end
      ST_NEG: begin
        g.b_hi = 1'b1;
        g.a_lo = 1'b1;
      end
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hbridge_deadtime_counter.sv
// Loadable down-counter timing the dead interval; expired_o flags the last
// cycle (count <= 1), so a load of 0 or 1 both give a single dead cycle.
module hbridge_deadtime_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q <= WIDTH'(1));

endmodule

// File: rtl/hbridge_deadtime_driver.sv
// Full-bridge gate driver: registers H1/H2 requests, inserts dead time on every
// conduction change, latches faults that force all gates off, counts pulses.
module hbridge_deadtime_driver
  import hbridge_pkg::*;
#(
  parameter int DEADTIME_WIDTH = 8,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      h1_req,
  input  logic                      h2_req,
  input  logic                      cfg_enable,
  input  logic [DEADTIME_WIDTH-1:0] cfg_deadtime,
  input  logic                      ext_fault,
  input  logic                      fault_clear,
  output logic                      gate_a_hi,
  output logic                      gate_a_lo,
  output logic                      gate_b_hi,
  output logic                      gate_b_lo,
  output logic                      fault,
  output logic [1:0]                fault_cause,
  output logic [COUNT_WIDTH-1:0]    pulse_count
);

  logic                   h1_q, h2_q;
  state_e                 state_q, state_d;
  gates_t                 gates_q;
  logic [1:0]             cause_q, cause_d;
  logic [COUNT_WIDTH-1:0] pulse_q, pulse_d;
  logic [1:0]             cmd;
  logic                   ill, fault_trig, dead_load, dead_expired;

  // An illegal pair faults even when disabled; otherwise disable means OFF.
  always_comb begin
    cmd = {h1_q, h2_q};
    if ((cmd != CMD_ILL) && !cfg_enable) begin
      cmd = CMD_OFF;
    end
  end

  assign ill        = (cmd == CMD_ILL);
  assign fault_trig = ill | ext_fault;

  hbridge_deadtime_counter #(
    .WIDTH(DEADTIME_WIDTH)
  ) u_dead_cnt (
    .clk      (clk),
    .reset    (reset),
    .load_i   (dead_load),
    .value_i  (cfg_deadtime),
    .dec_i    (state_q == ST_DEAD),
    .expired_o(dead_expired)
  );

  always_comb begin
    state_d   = state_q;
    dead_load = 1'b0;
    if (fault_trig) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (cmd == CMD_POS) state_d = ST_POS;
          else if (cmd == CMD_NEG) state_d = ST_NEG;
        end
        ST_POS: begin
          if (cmd != CMD_POS) begin
            state_d   = ST_DEAD;
            dead_load = 1'b1;
          end
        end
        ST_NEG: begin
          if (cmd != CMD_NEG) begin
            state_d   = ST_DEAD;
            dead_load = 1'b1;
          end
        end
        ST_DEAD: begin
          if (dead_expired) begin
            if (cmd == CMD_POS) state_d = ST_POS;
            else if (cmd == CMD_NEG) state_d = ST_NEG;
            else state_d = ST_OFF;
          end
        end
        ST_FAULT: begin
          if (fault_clear && (cmd == CMD_OFF)) begin
            state_d   = ST_DEAD;
            dead_load = 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    cause_d            = cause_q;
    cause_d[CAUSE_ILL] = cause_q[CAUSE_ILL] | ill;
    cause_d[CAUSE_EXT] = cause_q[CAUSE_EXT] | ext_fault;
    if ((state_q == ST_FAULT) && (state_d != ST_FAULT)) begin
      cause_d = '0;
    end
  end

  always_comb begin
    pulse_d = pulse_q;
    if (((state_d == ST_POS) && (state_q != ST_POS)) ||
        ((state_d == ST_NEG) && (state_q != ST_NEG))) begin
      pulse_d = pulse_q + COUNT_WIDTH'(1);
    end
  end

  // Gates are registered from the next state so they switch with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      h1_q    <= 1'b0;
      h2_q    <= 1'b0;
      state_q <= ST_OFF;
      gates_q <= '0;
      cause_q <= '0;
      pulse_q <= '0;
    end else begin
      h1_q    <= h1_req;
      h2_q    <= h2_req;
      state_q <= state_d;
      gates_q <= gate_decode(state_d);
      cause_q <= cause_d;
      pulse_q <= pulse_d;
    end
  end

  assign gate_a_hi   = gates_q.a_hi;
  assign gate_a_lo   = gates_q.a_lo;
  assign gate_b_hi   = gates_q.b_hi;
  assign gate_b_lo   = gates_q.b_lo;
  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = cause_q;
  assign pulse_count = pulse_q;

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// Directed bench for the H-bridge dead-time driver; expectations are queued with
// the cycle they are due and compared as the DUT reaches that cycle.
module tb_hbridge_deadtime_driver;

  logic        clk = 1'b0;
  logic        reset, h1_req, h2_req, cfg_enable, ext_fault, fault_clear;
  logic [7:0]  cfg_deadtime;
  logic        gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo, fault;
  logic [1:0]  fault_cause;
  logic [31:0] pulse_count;

  always #5 clk = ~clk;

  hbridge_deadtime_driver #(
    .DEADTIME_WIDTH(8),
    .COUNT_WIDTH   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .h1_req      (h1_req),
    .h2_req      (h2_req),
    .cfg_enable  (cfg_enable),
    .cfg_deadtime(cfg_deadtime),
    .ext_fault   (ext_fault),
    .fault_clear (fault_clear),
    .gate_a_hi   (gate_a_hi),
    .gate_a_lo   (gate_a_lo),
    .gate_b_hi   (gate_b_hi),
    .gate_b_lo   (gate_b_lo),
    .fault       (fault),
    .fault_cause (fault_cause),
    .pulse_count (pulse_count)
  );

  typedef struct {
    int          due;
    string       tag;
    logic [3:0]  g;
    logic        f;
    logic [1:0]  c;
    logic [31:0] pc;
  } exp_t;

  // Gate packing {a_hi, a_lo, b_hi, b_lo}
  localparam logic [3:0] G_OFF = 4'b0000;
  localparam logic [3:0] G_POS = 4'b1001;
  localparam logic [3:0] G_NEG = 4'b0110;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   k;

  task automatic expect_at(input int due, input string tag, input logic [3:0] g,
                           input logic f, input logic [1:0] c, input logic [31:0] pc);
    exp_t e;
    e.due = due; e.tag = tag; e.g = g; e.f = f; e.c = c; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t       e;
    logic [3:0] g;
    g = {gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo};
    checks++;
    assert (!(gate_a_hi & gate_a_lo) && !(gate_b_hi & gate_b_lo) && !(gate_a_hi & gate_b_hi))
    else begin
      errors++;
      $error("FAIL invariant cyc=%0d observed gates=%b required no shoot-through", cyc, g);
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      assert (g === e.g && fault === e.f && fault_cause === e.c && pulse_count === e.pc)
      else begin
        errors++;
        $error("FAIL %s cyc=%0d observed gates=%b fault=%b cause=%b count=%0d expected gates=%b fault=%b cause=%b count=%0d",
               e.tag, cyc, g, fault, fault_cause, pulse_count, e.g, e.f, e.c, e.pc);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; h1_req = 1'b0; h2_req = 1'b0; cfg_enable = 1'b1;
    cfg_deadtime = 8'd5; ext_fault = 1'b0; fault_clear = 1'b0;
    tick(2);
    expect_at(cyc, "reset_state", G_OFF, 1'b0, 2'b00, 32'd0);
    tick(1);

    k = cyc; reset = 1'b0; h1_req = 1'b1;
    expect_at(k + 1, "pos_latency", G_OFF, 1'b0, 2'b00, 32'd0);
    expect_at(k + 2, "pos_on", G_POS, 1'b0, 2'b00, 32'd1);
    tick(5);

    k = cyc; h1_req = 1'b0; h2_req = 1'b1;
    expect_at(k + 1, "pos_hold", G_POS, 1'b0, 2'b00, 32'd1);
    for (int i = 2; i <= 6; i++) expect_at(k + i, "dead5_pn", G_OFF, 1'b0, 2'b00, 32'd1);
    expect_at(k + 7, "neg_on", G_NEG, 1'b0, 2'b00, 32'd2);
    tick(9);

    k = cyc; h1_req = 1'b1; h2_req = 1'b0;
    expect_at(k + 1, "neg_hold", G_NEG, 1'b0, 2'b00, 32'd2);
    for (int i = 2; i <= 6; i++) expect_at(k + i, "dead5_np", G_OFF, 1'b0, 2'b00, 32'd2);
    expect_at(k + 7, "pos_again", G_POS, 1'b0, 2'b00, 32'd3);
    tick(9);

    k = cyc; cfg_deadtime = 8'd0; h1_req = 1'b0; h2_req = 1'b1;
    expect_at(k + 1, "dt0_hold", G_POS, 1'b0, 2'b00, 32'd3);
    expect_at(k + 2, "dt0_dead", G_OFF, 1'b0, 2'b00, 32'd3);
    expect_at(k + 3, "dt0_neg", G_NEG, 1'b0, 2'b00, 32'd4);
    tick(5);

    k = cyc; cfg_deadtime = 8'd255; h1_req = 1'b1; h2_req = 1'b0;
    expect_at(k + 1, "dt255_hold", G_NEG, 1'b0, 2'b00, 32'd4);
    for (int i = 2; i <= 256; i++) expect_at(k + i, "dt255_dead", G_OFF, 1'b0, 2'b00, 32'd4);
    expect_at(k + 257, "dt255_pos", G_POS, 1'b0, 2'b00, 32'd5);
    tick(260);

    k = cyc; cfg_deadtime = 8'd5; h1_req = 1'b0; h2_req = 1'b1;
    expect_at(k + 1, "toggle_hold", G_POS, 1'b0, 2'b00, 32'd5);
    for (int i = 2; i <= 6; i++) expect_at(k + i, "toggle_dead", G_OFF, 1'b0, 2'b00, 32'd5);
    expect_at(k + 7, "toggle_neg", G_NEG, 1'b0, 2'b00, 32'd6);
    tick(3);
    h1_req = 1'b1; h2_req = 1'b0;
    tick(1);
    h1_req = 1'b0; h2_req = 1'b1;
    tick(5);

    k = cyc; h1_req = 1'b1; h2_req = 1'b1;
    expect_at(k + 1, "ill_hold", G_NEG, 1'b0, 2'b00, 32'd6);
    expect_at(k + 2, "ill_fault", G_OFF, 1'b1, 2'b01, 32'd6);
    tick(4);

    k = cyc; fault_clear = 1'b1;
    expect_at(k + 1, "clr_ignored_ill", G_OFF, 1'b1, 2'b01, 32'd6);
    expect_at(k + 2, "clr_ignored_ill2", G_OFF, 1'b1, 2'b01, 32'd6);
    tick(3);
    h1_req = 1'b0; h2_req = 1'b0; fault_clear = 1'b0;
    tick(4);
    expect_at(cyc, "clr_not_remembered", G_OFF, 1'b1, 2'b01, 32'd6);
    tick(1);
    k = cyc; fault_clear = 1'b1;
    expect_at(k + 1, "ill_exit", G_OFF, 1'b0, 2'b00, 32'd6);
    expect_at(k + 6, "ill_exit_off", G_OFF, 1'b0, 2'b00, 32'd6);
    tick(1);
    fault_clear = 1'b0;
    tick(7);

    k = cyc; h1_req = 1'b1;
    expect_at(k + 2, "pos_from_off", G_POS, 1'b0, 2'b00, 32'd7);
    tick(4);
    k = cyc; ext_fault = 1'b1;
    expect_at(k + 1, "ext_fault", G_OFF, 1'b1, 2'b10, 32'd7);
    tick(2);
    h1_req = 1'b0; fault_clear = 1'b1;
    tick(3);
    expect_at(cyc, "clr_ignored_ext", G_OFF, 1'b1, 2'b10, 32'd7);
    tick(1);
    k = cyc; ext_fault = 1'b0;
    expect_at(k + 1, "ext_exit", G_OFF, 1'b0, 2'b00, 32'd7);
    tick(1);
    fault_clear = 1'b0;
    tick(7);

    k = cyc; ext_fault = 1'b1; h1_req = 1'b1; h2_req = 1'b1;
    expect_at(k + 1, "both_ext_first", G_OFF, 1'b1, 2'b10, 32'd7);
    expect_at(k + 2, "both_causes", G_OFF, 1'b1, 2'b11, 32'd7);
    tick(3);
    ext_fault = 1'b0; h1_req = 1'b0; h2_req = 1'b0;
    tick(3);
    k = cyc; fault_clear = 1'b1;
    expect_at(k + 1, "both_exit", G_OFF, 1'b0, 2'b00, 32'd7);
    tick(1);
    fault_clear = 1'b0;
    tick(7);

    k = cyc; h1_req = 1'b1;
    expect_at(k + 2, "pos_before_reset", G_POS, 1'b0, 2'b00, 32'd8);
    tick(4);
    k = cyc; reset = 1'b1;
    expect_at(k + 1, "reset_mid_pos", G_OFF, 1'b0, 2'b00, 32'd0);
    tick(2);
    k = cyc; reset = 1'b0; cfg_enable = 1'b0;
    expect_at(k + 1, "disabled", G_OFF, 1'b0, 2'b00, 32'd0);
    expect_at(k + 3, "disabled_hold", G_OFF, 1'b0, 2'b00, 32'd0);
    tick(4);
    k = cyc; cfg_enable = 1'b1;
    expect_at(k + 2, "enabled_pos", G_POS, 1'b0, 2'b00, 32'd1);
    tick(3);

    checks++;
    assert (sb.size() === 0)
    else begin
      errors++;
      $error("FAIL sb_drain observed %0d pending required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
